// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and width helpers for the buffered UART receiver
package uart_rx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
    typedef struct packed {
        logic framing;
        logic parity;
        logic overrun;
    } rx_err_t;
    localparam int BIT_CNT_W = 4;
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: show-ahead FIFO; a push while full is accepted only alongside a pop
module sync_fifo_fwft
    import uart_rx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [lvl_w(DEPTH)-1:0]  level
);
    localparam int PW = ptr_w(DEPTH);
    localparam int LW = lvl_w(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wp, rp;
    logic do_push, do_pop;
    assign empty   = level == '0;
    assign full    = level == LW'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rp];
    always_ff @(posedge clk)
        if (do_push) mem[wp] <= wdata;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
        end else begin
            wp    <= wp + PW'(do_push);
            rp    <= rp + PW'(do_pop);
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end
endmodule

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: oversampling UART receiver with parity, sticky errors and an RX FIFO
module uart_rx_buffered
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic [DIV_W-1:0]              clk_divider,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          sin,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_data_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          receiver_busy,
    output logic                          err_framing,
    output logic                          err_parity,
    output logic                          err_overrun
);
    localparam int SW = $clog2(OVERSAMPLE);
    rx_state_t state;
    rx_err_t err, set;
    logic [2:0] sync;
    logic [DIV_W-1:0] cnt;
    logic [SW-1:0] s;
    logic [BIT_CNT_W-1:0] nb;
    logic [DATA_BITS-1:0] sh;
    logic s_in, fall, tick, mid, smp, bad, par_bad, done, full, empty;
    // sync[1] is the synchronised input, sync[2] its previous value for edge detect
    assign s_in = sync[1];
    assign fall = sync[2] && !sync[1];
    assign receiver_busy = state != IDLE;
    assign tick = en && receiver_busy && cnt == clk_divider;
    assign mid  = tick && s == SW'(OVERSAMPLE/2 - 1);
    assign smp  = tick && s == SW'(OVERSAMPLE - 1);
    assign set  = {state == STOP && smp && !s_in, done && par_bad, done && !bad && full && !rd_en};
    assign rx_data_valid = !empty;
    assign {err_framing, err_parity, err_overrun} = err;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync <= '1;
        else sync <= {sync[1:0], sin};
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= (!tick && receiver_busy && en) ? cnt + 1'b1 : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            s       <= '0;
            nb      <= '0;
            sh      <= '0;
            bad     <= 1'b0;
            par_bad <= 1'b0;
            done    <= 1'b0;
        end else if (!en) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (tick) s <= smp || mid && state == START ? '0 : s + 1'b1;
            case (state)
                IDLE: if (fall) begin
                    state   <= START;
                    s       <= '0;
                    nb      <= '0;
                    bad     <= 1'b0;
                    par_bad <= 1'b0;
                end
                START: if (mid) state <= s_in ? IDLE : DATA;
                DATA: if (smp) begin
                    sh <= {s_in, sh[DATA_BITS-1:1]};
                    nb <= nb + 1'b1;
                    if (nb == BIT_CNT_W'(DATA_BITS - 1)) state <= parity_en ? PARITY : STOP;
                end
                PARITY: if (smp) begin
                    par_bad <= s_in != (^sh ^ parity_odd);
                    state   <= STOP;
                end
                STOP: if (smp) begin
                    bad   <= par_bad || !s_in;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    // a set event in the same cycle as clr_err wins
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) err <= '0;
        else err <= (err & ~{3{clr_err}}) | set;
    sync_fifo_fwft #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (done && !bad),
        .wdata (sh),
        .pop   (rd_en),
        .rdata (rx_data),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );
endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered: directed frames at 16 clocks per bit with hand-computed expectations
module tb_uart_rx_buffered;
    logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, parity_en = 1'b0, parity_odd = 1'b0;
    logic sin = 1'b1, rd_en = 1'b0, clr_err = 1'b0;
    logic [15:0] clk_divider = '0;
    logic [7:0] rx_data;
    logic [3:0] fifo_level;
    logic rx_data_valid, receiver_busy, err_framing, err_parity, err_overrun;
    int total = 0, passes = 0;
    uart_rx_buffered dut (
        .clk(clk), .rst_n(rst_n), .en(en), .clk_divider(clk_divider),
        .parity_en(parity_en), .parity_odd(parity_odd), .sin(sin), .rd_en(rd_en),
        .clr_err(clr_err), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
        .fifo_level(fifo_level), .receiver_busy(receiver_busy), .err_framing(err_framing),
        .err_parity(err_parity), .err_overrun(err_overrun)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask
    task automatic send_bit(input logic b);
        sin = b;
        repeat (16) @(negedge clk);
    endtask
    task automatic send_frame(input logic [7:0] d, input logic pb_on, input logic pb, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (pb_on) send_bit(pb);
        send_bit(stop);
    endtask
    task automatic pop_one();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask
    task automatic chk_errs(input string tag, input logic [2:0] exp);
        chk(tag, {err_framing, err_parity, err_overrun}, exp);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk("reset rx_data", rx_data, 0);
        chk("reset valid", rx_data_valid, 0);
        chk("reset level", fifo_level, 0);
        chk("reset busy", receiver_busy, 0);
        chk_errs("reset errs", 3'b000);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        chk("a5 data", rx_data, 8'hA5);
        chk("a5 valid", rx_data_valid, 1);
        chk("a5 level", fifo_level, 1);
        chk_errs("a5 errs", 3'b000);
        pop_one();
        chk("a5 pop level", fifo_level, 0);
        chk("a5 pop valid", rx_data_valid, 0);
        parity_en = 1'b1;
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        chk_errs("bad parity errs", 3'b010);
        chk("bad parity level", fifo_level, 0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk_errs("parity clr", 3'b000);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        chk("good parity data", rx_data, 8'h07);
        chk("good parity level", fifo_level, 1);
        chk_errs("good parity errs", 3'b000);
        pop_one();
        parity_en = 1'b0;
        repeat (4) @(negedge clk);
        sin = 1'b0;
        repeat (4) @(negedge clk);
        sin = 1'b1;
        repeat (2) @(negedge clk);
        chk("false start busy mid", receiver_busy, 1);
        repeat (10) @(negedge clk);
        chk("false start busy", receiver_busy, 0);
        chk("false start level", fifo_level, 0);
        chk_errs("false start errs", 3'b000);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        sin = 1'b1;
        repeat (20) @(negedge clk);
        chk_errs("framing errs", 3'b100);
        chk("framing level", fifo_level, 0);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        chk("after framing data", rx_data, 8'h11);
        chk("after framing level", fifo_level, 1);
        chk_errs("framing sticky", 3'b100);
        pop_one();
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk_errs("framing clr", 3'b000);
        sin = 1'b0;
        repeat (40) @(negedge clk);
        chk("en drop busy before", receiver_busy, 1);
        en = 1'b0;
        @(negedge clk);
        chk("en drop busy after", receiver_busy, 0);
        sin = 1'b1;
        repeat (200) @(negedge clk);
        en = 1'b1;
        repeat (4) @(negedge clk);
        chk("en drop level", fifo_level, 0);
        chk_errs("en drop errs", 3'b000);
        for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b0, 1'b0, 1'b1);
        chk("full level", fifo_level, 8);
        chk_errs("overrun errs", 3'b001);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("pop order %0d", i), rx_data, i);
            pop_one();
        end
        chk("drained valid", rx_data_valid, 0);
        send_frame(8'h21, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        chk("pre-reset level", fifo_level, 2);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        chk("pre-reset busy", receiver_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid reset rx_data", rx_data, 0);
        chk("mid reset valid", rx_data_valid, 0);
        chk("mid reset level", fifo_level, 0);
        chk("mid reset busy", receiver_busy, 0);
        chk_errs("mid reset errs", 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        chk("post reset data", rx_data, 8'h3C);
        chk("post reset level", fifo_level, 1);
        chk_errs("post reset errs", 3'b000);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
